ntm_read_heads_scheduler: RTL and testbench

- Sequences the R read heads of the NTM accelerator over one shared read-vector engine, one head at a time.
- The engine computes r(i;k) = sum_j w(i;j)*M(j;k).
- Per head, the block pulses the engine start, waits for engine done, and forwards the engine's W result words out, tagged with head and word indices.
- Sits between the NTM top-level controller and the read-head datapath.

---
 rtl/ntm_read_heads_scheduler.sv | 198 +++++++++++++++++++
 tb/tb_ntm_read_heads_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntm_read_heads_scheduler.sv
//==============================================================================
// Module      : ntm_read_heads_scheduler
// Description : Runs the R read heads of the NTM accelerator one at a time on
//               a single shared read-vector engine. For each head it pulses the
//               engine start, forwards the W result words tagged with
//               (head, word) indices, and waits for the engine's done signal.
// Options     : define ACCELERATOR_READ_HEADS_TIMEOUT_EN to add a per-head
//               watchdog and the timeout_o flag.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module ntm_read_heads_scheduler #(
    parameter int DATA_SIZE      = 64,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    output logic                 ready_o,
    input  logic [DATA_SIZE-1:0] size_r_in_i,
    input  logic [DATA_SIZE-1:0] size_n_in_i,
    input  logic [DATA_SIZE-1:0] size_w_in_i,
    output logic                 engine_start_o,
    input  logic                 engine_ready_i,
    output logic [DATA_SIZE-1:0] engine_index_o,
    output logic [DATA_SIZE-1:0] engine_size_n_o,
    output logic [DATA_SIZE-1:0] engine_size_w_o,
    input  logic                 engine_r_enable_i,
    input  logic [DATA_SIZE-1:0] engine_r_data_i,
    output logic                 r_out_i_enable_o,
    output logic                 r_out_k_enable_o,
    output logic [DATA_SIZE-1:0] r_out_data_o,
    output logic [DATA_SIZE-1:0] r_out_i_o,
    output logic [DATA_SIZE-1:0] r_out_k_o,
`ifdef ACCELERATOR_READ_HEADS_TIMEOUT_EN
    output logic                 timeout_o,
`endif
    output logic                 error_o
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LATCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_NEXT  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]           state_q, state_d;
    logic [DATA_SIZE-1:0] r_q, n_q, w_q;
    logic [DATA_SIZE-1:0] i_q, k_q;
    logic                 error_q;
    logic                 r_out_i_enable_q, r_out_k_enable_q;
    logic [DATA_SIZE-1:0] r_out_data_q, r_out_i_q, r_out_k_q;

    logic                 w_in_wait;
    logic                 w_fwd;
    logic                 w_drop;
    logic [DATA_SIZE-1:0] w_k_after;
    logic                 w_count_bad;
    logic                 w_last_head;
    logic                 w_timeout_hit;

    // Word accounting: a word arriving with ENGINE_READY is counted before the check
    assign w_in_wait   = (state_q == S_WAIT);
    assign w_fwd       = w_in_wait && engine_r_enable_i && (k_q < w_q);
    assign w_drop      = w_in_wait && engine_r_enable_i && !(k_q < w_q);
    assign w_k_after   = k_q + {{(DATA_SIZE-1){1'b0}}, w_fwd};
    assign w_count_bad = w_in_wait && engine_ready_i && (w_k_after != w_q);
    assign w_last_head = (i_q == (r_q - {{(DATA_SIZE-1){1'b0}}, 1'b1}));

`ifdef ACCELERATOR_READ_HEADS_TIMEOUT_EN
    logic [DATA_SIZE-1:0] wd_q;
    logic                 timeout_q;

    assign w_timeout_hit = w_in_wait && !engine_ready_i &&
                           (wd_q == DATA_SIZE'(TIMEOUT_CYCLES - 1));
    assign timeout_o     = timeout_q;

    // Per-head watchdog, restarted on every issue and flagged stickily on expiry
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state_q == S_IDLE && start_i) begin
                timeout_q <= 1'b0;
            end
            if (state_q == S_ISSUE) begin
                wd_q <= '0;
            end else if (w_in_wait) begin
                wd_q <= wd_q + {{(DATA_SIZE-1){1'b0}}, 1'b1};
            end
            if (w_timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign w_timeout_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_i) state_d = S_LATCH;
            S_LATCH: state_d = (r_q == '0) ? S_DONE : S_ISSUE;
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (engine_ready_i)     state_d = S_NEXT;
                else if (w_timeout_hit) state_d = S_DONE;
            end
            S_NEXT:  state_d = w_last_head ? S_DONE : S_ISSUE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        engine_start_o = (state_q == S_ISSUE);
        ready_o        = (state_q == S_DONE);
    end

    // Schedule datapath: size latches, head/word counters, result forwarding
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_q              <= '0;
            n_q              <= '0;
            w_q              <= '0;
            i_q              <= '0;
            k_q              <= '0;
            error_q          <= 1'b0;
            r_out_i_enable_q <= 1'b0;
            r_out_k_enable_q <= 1'b0;
            r_out_data_q     <= '0;
            r_out_i_q        <= '0;
            r_out_k_q        <= '0;
        end else begin
            r_out_i_enable_q <= 1'b0;
            r_out_k_enable_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        r_q     <= size_r_in_i;
                        n_q     <= size_n_in_i;
                        w_q     <= size_w_in_i;
                        error_q <= 1'b0;
                    end
                end
                S_LATCH: i_q <= '0;
                S_ISSUE: k_q <= '0;
                S_WAIT: begin
                    if (w_fwd) begin
                        r_out_data_q     <= engine_r_data_i;
                        r_out_i_q        <= i_q;
                        r_out_k_q        <= k_q;
                        r_out_k_enable_q <= 1'b1;
                        r_out_i_enable_q <= (k_q == '0);
                        k_q              <= w_k_after;
                    end
                    if (w_drop || w_count_bad) begin
                        error_q <= 1'b1;
                    end
                end
                S_NEXT: begin
                    if (!w_last_head) begin
                        i_q <= i_q + {{(DATA_SIZE-1){1'b0}}, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end

    assign engine_index_o   = i_q;
    assign engine_size_n_o  = n_q;
    assign engine_size_w_o  = w_q;
    assign r_out_i_enable_o = r_out_i_enable_q;
    assign r_out_k_enable_o = r_out_k_enable_q;
    assign r_out_data_o     = r_out_data_q;
    assign r_out_i_o        = r_out_i_q;
    assign r_out_k_o        = r_out_k_q;
    assign error_o          = error_q;

endmodule

`default_nettype wire

// File: tb/tb_ntm_read_heads_scheduler.sv
//==============================================================================
// Module      : tb_ntm_read_heads_scheduler
// Description : Directed self-checking bench for ntm_read_heads_scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ntm_read_heads_scheduler;

    localparam int DS = 64;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [DS-1:0] size_r, size_n, size_w;
    logic          engine_ready, engine_r_en;
    logic [DS-1:0] engine_r_data;
    logic          ready, engine_start, r_out_i_en, r_out_k_en, error;
    logic [DS-1:0] engine_index, engine_size_n, engine_size_w;
    logic [DS-1:0] r_out_data, r_out_i, r_out_k;
`ifdef ACCELERATOR_READ_HEADS_TIMEOUT_EN
    logic          timeout;
`endif

    always #5 clk = ~clk;

    ntm_read_heads_scheduler #(.DATA_SIZE(DS), .TIMEOUT_CYCLES(16)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .start_i           (start),
        .ready_o           (ready),
        .size_r_in_i       (size_r),
        .size_n_in_i       (size_n),
        .size_w_in_i       (size_w),
        .engine_start_o    (engine_start),
        .engine_ready_i    (engine_ready),
        .engine_index_o    (engine_index),
        .engine_size_n_o   (engine_size_n),
        .engine_size_w_o   (engine_size_w),
        .engine_r_enable_i (engine_r_en),
        .engine_r_data_i   (engine_r_data),
        .r_out_i_enable_o  (r_out_i_en),
        .r_out_k_enable_o  (r_out_k_en),
        .r_out_data_o      (r_out_data),
        .r_out_i_o         (r_out_i),
        .r_out_k_o         (r_out_k),
`ifdef ACCELERATOR_READ_HEADS_TIMEOUT_EN
        .timeout_o         (timeout),
`endif
        .error_o           (error)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    int st_cyc;

    // Cycle label: value of cyc during the interval following each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    int            ie_cnt, rdy_cnt, rdy_cyc;
    int            es_cyc[$];
    logic [DS-1:0] es_idx[$];
    logic [DS-1:0] wi[$], wk[$], wd[$];

    // Event recorder, sampled just after each rising edge
    always @(posedge clk) begin
        #1;
        if (engine_start) begin
            es_idx.push_back(engine_index);
            es_cyc.push_back(cyc);
        end
        if (r_out_k_en) begin
            wi.push_back(r_out_i);
            wk.push_back(r_out_k);
            wd.push_back(r_out_data);
        end
        if (r_out_i_en) ie_cnt++;
        if (ready) begin
            rdy_cnt++;
            rdy_cyc = cyc;
        end
    end

    task automatic clear_mon();
        es_cyc.delete(); es_idx.delete();
        wi.delete(); wk.delete(); wd.delete();
        ie_cnt = 0; rdy_cnt = 0; rdy_cyc = -1;
    endtask

    task automatic start_sched(input int r, input int n, input int w);
        @(negedge clk);
        size_r = DS'(r); size_n = DS'(n); size_w = DS'(w);
        start  = 1'b1;
        st_cyc = cyc;
        @(negedge clk);
        start  = 1'b0;
    endtask

    // Engine model for one head: waits for a start pulse, sends nwords words
    // (data 1000 + 16*head + k), then raises ENGINE_READY (optionally with the last word)
    task automatic serve_head(input int nwords, input bit same, output int u);
        bit            found = 1'b0;
        logic [DS-1:0] h = '0;
        u = -1;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (engine_start) begin
                found = 1'b1;
                h     = engine_index;
            end
        end
        if (!found) begin
            $display("FAIL serve_head: no engine start seen within 40 cycles, wanted one");
            n_err++; n_vec++;
        end else begin
            for (int j = 0; j < nwords; j++) begin
                @(negedge clk);
                engine_r_en   = 1'b1;
                engine_r_data = 1000 + h * 16 + DS'(j);
                engine_ready  = same && (j == nwords - 1);
                u = cyc;
            end
            if (!(same && nwords > 0)) begin
                @(negedge clk);
                engine_r_en  = 1'b0;
                engine_ready = 1'b1;
                u = cyc;
            end
            @(negedge clk);
            engine_r_en  = 1'b0;
            engine_ready = 1'b0;
        end
    endtask

    task automatic wait_ready(input int target);
        for (int c = 0; c < 80 && rdy_cnt < target; c++) @(negedge clk);
        if (rdy_cnt < target) begin
            $display("FAIL wait_ready: ready count %0d, expected %0d", rdy_cnt, target);
            n_err++; n_vec++;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        #23;
        n_vec++; if (ready !== 1'b0)        begin $display("FAIL rst_ready: got %b want 0", ready); n_err++; end
        n_vec++; if (engine_start !== 1'b0) begin $display("FAIL rst_estart: got %b want 0", engine_start); n_err++; end
        n_vec++; if (engine_index !== '0)   begin $display("FAIL rst_index: got %0d want 0", engine_index); n_err++; end
        n_vec++; if (r_out_k_en !== 1'b0 || r_out_i_en !== 1'b0) begin $display("FAIL rst_rout_en: got %b%b want 00", r_out_i_en, r_out_k_en); n_err++; end
        n_vec++; if (r_out_data !== '0 || r_out_i !== '0 || r_out_k !== '0) begin $display("FAIL rst_rout: got %0d/%0d/%0d want 0", r_out_data, r_out_i, r_out_k); n_err++; end
        n_vec++; if (error !== 1'b0)        begin $display("FAIL rst_error: got %b want 0", error); n_err++; end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int u[3];
        clear_mon();
        start_sched(3, 8, 4);
        for (int h = 0; h < 3; h++) serve_head(4, 1'b0, u[h]);
        wait_ready(1);
        n_vec++; if (es_idx.size() != 3) begin $display("FAIL basic_nstart: got %0d want 3", es_idx.size()); n_err++; end
        for (int h = 0; h < 3 && h < es_idx.size(); h++) begin
            n_vec++; if (es_idx[h] !== DS'(h)) begin $display("FAIL basic_index%0d: got %0d want %0d", h, es_idx[h], h); n_err++; end
        end
        if (es_cyc.size() >= 2) begin
            n_vec++; if (es_cyc[0] != st_cyc + 2) begin $display("FAIL basic_first_latency: got %0d want %0d", es_cyc[0], st_cyc + 2); n_err++; end
            n_vec++; if (es_cyc[1] != u[0] + 2)   begin $display("FAIL basic_next_latency: got %0d want %0d", es_cyc[1], u[0] + 2); n_err++; end
        end
        n_vec++; if (rdy_cyc != u[2] + 2) begin $display("FAIL basic_ready_latency: got %0d want %0d", rdy_cyc, u[2] + 2); n_err++; end
        n_vec++; if (wi.size() != 12) begin $display("FAIL basic_nwords: got %0d want 12", wi.size()); n_err++; end
        for (int n = 0; n < 12 && n < wi.size(); n++) begin
            n_vec++;
            if (wi[n] !== DS'(n / 4) || wk[n] !== DS'(n % 4) || wd[n] !== DS'(1000 + 16 * (n / 4) + (n % 4))) begin
                $display("FAIL basic_word%0d: got i=%0d k=%0d d=%0d want i=%0d k=%0d d=%0d",
                         n, wi[n], wk[n], wd[n], n / 4, n % 4, 1000 + 16 * (n / 4) + (n % 4));
                n_err++;
            end
        end
        n_vec++; if (ie_cnt != 3)  begin $display("FAIL basic_ienable: got %0d want 3", ie_cnt); n_err++; end
        n_vec++; if (rdy_cnt != 1) begin $display("FAIL basic_ready_count: got %0d want 1", rdy_cnt); n_err++; end
        n_vec++; if (error !== 1'b0) begin $display("FAIL basic_error: got %b want 0", error); n_err++; end
        n_vec++; if (engine_size_n !== DS'(8) || engine_size_w !== DS'(4)) begin $display("FAIL basic_sizes: got n=%0d w=%0d want 8 4", engine_size_n, engine_size_w); n_err++; end
    endtask

    task automatic test_zero_heads();
        clear_mon();
        start_sched(0, 5, 5);
        wait_ready(1);
        n_vec++; if (rdy_cyc != st_cyc + 2) begin $display("FAIL zero_ready_latency: got %0d want %0d", rdy_cyc, st_cyc + 2); n_err++; end
        n_vec++; if (es_idx.size() != 0 || wi.size() != 0) begin $display("FAIL zero_activity: got %0d starts %0d words want 0 0", es_idx.size(), wi.size()); n_err++; end
    endtask

    task automatic test_short_count();
        int u;
        clear_mon();
        start_sched(2, 8, 4);
        serve_head(2, 1'b0, u);
        serve_head(4, 1'b0, u);
        wait_ready(1);
        n_vec++; if (error !== 1'b1) begin $display("FAIL short_error: got %b want 1", error); n_err++; end
        n_vec++; if (es_idx.size() != 2) begin $display("FAIL short_nstart: got %0d want 2", es_idx.size()); n_err++; end
        n_vec++; if (wi.size() != 6) begin $display("FAIL short_nwords: got %0d want 6", wi.size()); n_err++; end
        n_vec++; if (rdy_cnt != 1) begin $display("FAIL short_ready: got %0d want 1", rdy_cnt); n_err++; end
        clear_mon();
        start_sched(0, 1, 1);
        n_vec++; if (error !== 1'b0) begin $display("FAIL short_error_clear: got %b want 0", error); n_err++; end
        wait_ready(1);
    endtask

    task automatic test_overflow();
        int u;
        clear_mon();
        start_sched(1, 4, 2);
        serve_head(3, 1'b0, u);
        wait_ready(1);
        n_vec++; if (wi.size() != 2) begin $display("FAIL ovf_nwords: got %0d want 2", wi.size()); n_err++; end
        if (wk.size() == 2) begin
            n_vec++; if (wk[0] !== DS'(0) || wk[1] !== DS'(1) || wd[1] !== DS'(1001)) begin $display("FAIL ovf_words: got k=%0d,%0d d1=%0d want 0,1 1001", wk[0], wk[1], wd[1]); n_err++; end
        end
        n_vec++; if (error !== 1'b1) begin $display("FAIL ovf_error: got %b want 1", error); n_err++; end
    endtask

    task automatic test_same_cycle();
        int u;
        clear_mon();
        start_sched(1, 4, 2);
        serve_head(2, 1'b1, u);
        wait_ready(1);
        n_vec++; if (error !== 1'b0) begin $display("FAIL same_error: got %b want 0", error); n_err++; end
        n_vec++; if (wi.size() != 2) begin $display("FAIL same_nwords: got %0d want 2", wi.size()); n_err++; end
        n_vec++; if (rdy_cyc != u + 2) begin $display("FAIL same_ready_latency: got %0d want %0d", rdy_cyc, u + 2); n_err++; end
        clear_mon();
        start_sched(1, 4, 0);
        serve_head(0, 1'b0, u);
        wait_ready(1);
        n_vec++; if (error !== 1'b0 || wi.size() != 0 || ie_cnt != 0) begin $display("FAIL wzero: got err=%b words=%0d ie=%0d want 0 0 0", error, wi.size(), ie_cnt); n_err++; end
    endtask

    task automatic test_start_and_reset();
        int u;
        bit found = 1'b0;
        clear_mon();
        start_sched(2, 4, 2);
        // head 0 with a stray START during WAIT
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            found = engine_start;
        end
        @(negedge clk); start = 1'b1; engine_r_en = 1'b1; engine_r_data = 1000;
        @(negedge clk); start = 1'b0; engine_r_data = 1001;
        @(negedge clk); engine_r_en = 1'b0; engine_ready = 1'b1;
        @(negedge clk); engine_ready = 1'b0;
        // head 1: one word, then asynchronous reset mid-WAIT
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            found = engine_start;
        end
        @(negedge clk); engine_r_en = 1'b1; engine_r_data = 1016;
        @(posedge clk); #2;
        engine_r_en = 1'b0;
        n_vec++; if (es_idx.size() != 2 || es_idx[1] !== DS'(1)) begin $display("FAIL sr_heads: got %0d starts, last index %0d, want 2 and 1", es_idx.size(), (es_idx.size() > 0) ? es_idx[es_idx.size() - 1] : '0); n_err++; end
        rst_n = 1'b0;
        #1;
        n_vec++; if (r_out_k_en !== 1'b0 || r_out_data !== '0 || r_out_i !== '0 || r_out_k !== '0) begin $display("FAIL sr_rout_reset: got en=%b d=%0d i=%0d k=%0d want all 0", r_out_k_en, r_out_data, r_out_i, r_out_k); n_err++; end
        n_vec++; if (engine_index !== '0 || engine_size_n !== '0 || engine_size_w !== '0 || ready !== 1'b0 || engine_start !== 1'b0) begin $display("FAIL sr_engine_reset: got idx=%0d n=%0d w=%0d rdy=%b es=%b want all 0", engine_index, engine_size_n, engine_size_w, ready, engine_start); n_err++; end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_mon();
        @(negedge clk); engine_r_en = 1'b1; engine_r_data = 77; engine_ready = 1'b1;
        @(negedge clk); engine_r_en = 1'b0; engine_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++; if (wi.size() != 0 || es_idx.size() != 0 || rdy_cnt != 0) begin $display("FAIL sr_idle_ignore: got %0d words %0d starts %0d ready want 0", wi.size(), es_idx.size(), rdy_cnt); n_err++; end
        start_sched(1, 4, 1);
        serve_head(1, 1'b0, u);
        wait_ready(1);
        n_vec++; if (es_idx.size() != 1 || es_idx[0] !== '0) begin $display("FAIL sr_restart_index: got %0d starts first %0d want 1 start at 0", es_idx.size(), (es_idx.size() > 0) ? es_idx[0] : '1); n_err++; end
        n_vec++; if (wi.size() != 1 || wi[0] !== '0 || wk[0] !== '0 || wd[0] !== DS'(1000)) begin $display("FAIL sr_restart_word: got %0d words want one word i=0 k=0 d=1000", wi.size()); n_err++; end
    endtask

`ifdef ACCELERATOR_READ_HEADS_TIMEOUT_EN
    task automatic test_timeout();
        clear_mon();
        start_sched(2, 4, 4);
        wait_ready(1);
        n_vec++; if (timeout !== 1'b1) begin $display("FAIL to_flag: got %b want 1", timeout); n_err++; end
        n_vec++; if (es_idx.size() != 1) begin $display("FAIL to_nstart: got %0d want 1", es_idx.size()); n_err++; end
        if (es_cyc.size() == 1) begin
            n_vec++; if (rdy_cyc != es_cyc[0] + 17) begin $display("FAIL to_ready_cycle: got %0d want %0d", rdy_cyc, es_cyc[0] + 17); n_err++; end
        end
        clear_mon();
        start_sched(0, 1, 1);
        n_vec++; if (timeout !== 1'b0) begin $display("FAIL to_clear: got %b want 0", timeout); n_err++; end
        wait_ready(1);
    endtask
`endif

    initial begin
        rst_n = 1'b0; start = 1'b0;
        size_r = '0; size_n = '0; size_w = '0;
        engine_ready = 1'b0; engine_r_en = 1'b0; engine_r_data = '0;
        clear_mon();
        test_reset();
        test_basic();
        test_zero_heads();
        test_short_count();
        test_overflow();
        test_same_cycle();
        test_start_and_reset();
`ifdef ACCELERATOR_READ_HEADS_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
